// File: rtl/conveyor_pkg.sv
// Shared constants for the bottling conveyor: state encodings and default timing.
package conveyor_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MOVE  = 3'd1;
  localparam logic [2:0] FILL  = 3'd2;
  localparam logic [2:0] CAP   = 3'd3;
  localparam logic [2:0] ERROR = 3'd4;

  localparam int unsigned DEF_TICK_DIV     = 50_000_000;
  localparam int unsigned DEF_MOVE_TIMEOUT = 15;
  localparam int unsigned DEF_FILL_TIMEOUT = 10;
  localparam int unsigned DEF_CAP_TICKS    = 2;
  localparam int unsigned DEF_COUNT_W      = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input, clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/conveyor_fill_controller.sv
// Bottling conveyor sequencer: move / fill / cap per bottle, paced by a tick prescaler,
// with timeout alarm and a modulo bottle counter.
module conveyor_fill_controller
  import conveyor_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned MOVE_TIMEOUT = DEF_MOVE_TIMEOUT,
  parameter int unsigned FILL_TIMEOUT = DEF_FILL_TIMEOUT,
  parameter int unsigned CAP_TICKS    = DEF_CAP_TICKS,
  parameter int unsigned COUNT_W      = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pos_sensor,
  input  logic               L,
  output logic               motor,
  output logic               valve,
  output logic               capper,
  output logic [COUNT_W-1:0] bottle_cnt,
  output logic               alarm,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned MAX_A     = (MOVE_TIMEOUT > FILL_TIMEOUT) ? MOVE_TIMEOUT : FILL_TIMEOUT;
  localparam int unsigned MAX_B     = (MAX_A > CAP_TICKS) ? MAX_A : CAP_TICKS;
  localparam int unsigned MAX_TICKS = (MAX_B > 1) ? MAX_B : 1;
  localparam int unsigned PRESC_W   = $clog2(TICK_DIV);
  localparam int unsigned TCNT_W    = $clog2(MAX_TICKS + 1);

  logic start_s, stop_s, pos_s, lvl_s;
  logic pos_prev;
  logic pos_rise;

  logic [PRESC_W-1:0] presc;
  logic [TCNT_W-1:0]  tick_cnt;
  logic               tick;
  logic               move_to, fill_to, cap_done;

  logic [STATE_W-1:0] state, state_nxt;
  logic               state_chg;

  sync_2ff u_sync_start (.clk(clk), .rst_n(rst_n), .d(start),      .q(start_s));
  sync_2ff u_sync_stop  (.clk(clk), .rst_n(rst_n), .d(stop),       .q(stop_s));
  sync_2ff u_sync_pos   (.clk(clk), .rst_n(rst_n), .d(pos_sensor), .q(pos_s));
  sync_2ff u_sync_lvl   (.clk(clk), .rst_n(rst_n), .d(L),          .q(lvl_s));

  always_ff @(posedge clk) begin
    if (!rst_n) pos_prev <= 1'b0;
    else        pos_prev <= pos_s;
  end

  assign pos_rise = pos_s & ~pos_prev;

  // A timeout "reaches" N on the tick that takes tick_cnt from N-1 to N.
  assign tick     = (presc == PRESC_W'(TICK_DIV - 1));
  assign move_to  = tick && (tick_cnt == TCNT_W'(MOVE_TIMEOUT - 1));
  assign fill_to  = tick && (tick_cnt == TCNT_W'(FILL_TIMEOUT - 1));
  assign cap_done = tick && (tick_cnt == TCNT_W'(CAP_TICKS - 1));

  assign state_chg = (state_nxt != state);

  // Prescaler and tick timer restart on every state change.
  always_ff @(posedge clk) begin
    if (!rst_n || state_chg) begin
      presc    <= '0;
      tick_cnt <= '0;
    end else if (tick) begin
      presc    <= '0;
      tick_cnt <= tick_cnt + TCNT_W'(1);
    end else begin
      presc    <= presc + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state != ERROR && stop_s) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_s) state_nxt = MOVE;
        MOVE:    if (pos_rise) state_nxt = FILL;
                 else if (move_to) state_nxt = ERROR;
        FILL:    if (lvl_s) state_nxt = CAP;
                 else if (fill_to) state_nxt = ERROR;
        CAP:     if (cap_done) state_nxt = MOVE;
        ERROR:   if (stop_s) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Moore outputs registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      motor  <= 1'b0;
      valve  <= 1'b0;
      capper <= 1'b0;
      alarm  <= 1'b0;
    end else begin
      motor  <= (state_nxt == MOVE);
      valve  <= (state_nxt == FILL);
      capper <= (state_nxt == CAP);
      alarm  <= (state_nxt == ERROR);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                                  bottle_cnt <= '0;
    else if (state == CAP && state_nxt == MOVE)  bottle_cnt <= bottle_cnt + COUNT_W'(1);
  end

  assign state_o = state;

endmodule

// File: tb/tb_conveyor_fill_controller.sv
// Directed bench for conveyor_fill_controller with small timing parameters.
module tb_conveyor_fill_controller;
  import conveyor_pkg::*;

  localparam int unsigned CW = 4;
  localparam int SIG_NONE = 0;
  localparam int SIG_POS  = 1;
  localparam int SIG_L    = 2;
  localparam int NV       = 14;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, pos_sensor, L;
  logic          motor, valve, capper, alarm;
  logic [CW-1:0] bottle_cnt;
  logic [2:0]    state_o;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CW-1:0] exp_cnt;
  logic [CW-1:0] cnt0;
  int            w;

  typedef struct {
    logic          start, stop, pos, lvl;
    int            cycles;
    logic [2:0]    st;
    logic          mo, va, ca, al;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  conveyor_fill_controller #(
    .TICK_DIV(4), .MOVE_TIMEOUT(5), .FILL_TIMEOUT(3), .CAP_TICKS(2), .COUNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pos_sensor(pos_sensor), .L(L),
    .motor(motor), .valve(valve), .capper(capper), .bottle_cnt(bottle_cnt),
    .alarm(alarm), .state_o(state_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge and check actuator exclusivity.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n === 1'b1)
      check("one_actuator", 32'(motor) + 32'(valve) + 32'(capper) <= 32'd1 ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n;
    n = 0;
    while (state_o !== s && n < 50) begin
      step();
      n++;
    end
    check(name, 32'(state_o), 32'(s));
  endtask

  // Count cycles spent in state s, optionally raising pos_sensor or L after act_at cycles.
  task automatic run_phase(input logic [2:0] s, input int act_at, input int sig, output int width);
    width = 0;
    while (state_o === s && width < 100) begin
      if (width == act_at) begin
        if (sig == SIG_POS)    pos_sensor = 1'b1;
        else if (sig == SIG_L) L = 1'b1;
      end
      step();
      width++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    //          start stop pos  lvl  cyc  state  mo   va   ca   al   cnt
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0, 3, IDLE,  1'b0,1'b0,1'b0,1'b0,4'd0};
    vecs[1]  = '{1'b1,1'b1,1'b0,1'b0, 4, IDLE,  1'b0,1'b0,1'b0,1'b0,4'd0};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0, 3, MOVE,  1'b1,1'b0,1'b0,1'b0,4'd0};
    vecs[3]  = '{1'b0,1'b0,1'b1,1'b0, 3, FILL,  1'b0,1'b1,1'b0,1'b0,4'd0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b1, 3, CAP,   1'b0,1'b0,1'b1,1'b0,4'd0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0, 8, MOVE,  1'b1,1'b0,1'b0,1'b0,4'd1};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b0, 3, FILL,  1'b0,1'b1,1'b0,1'b0,4'd1};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,12, ERROR, 1'b0,1'b0,1'b0,1'b1,4'd1};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b0, 5, ERROR, 1'b0,1'b0,1'b0,1'b1,4'd1};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0, 3, IDLE,  1'b0,1'b0,1'b0,1'b0,4'd1};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0, 3, IDLE,  1'b0,1'b0,1'b0,1'b0,4'd1};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b0, 3, MOVE,  1'b1,1'b0,1'b0,1'b0,4'd1};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,20, ERROR, 1'b0,1'b0,1'b0,1'b1,4'd1};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b0, 3, IDLE,  1'b0,1'b0,1'b0,1'b0,4'd1};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pos_sensor = 1'b0; L = 1'b0;
    step(); step();
    check("rst state",  32'(state_o), 32'(IDLE));
    check("rst outs",   32'({motor, valve, capper, alarm}), 32'd0);
    check("rst cnt",    32'(bottle_cnt), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      start = vecs[i].start; stop = vecs[i].stop; pos_sensor = vecs[i].pos; L = vecs[i].lvl;
      for (int c = 0; c < vecs[i].cycles; c++) step();
      check($sformatf("vec%0d state", i),  32'(state_o),    32'(vecs[i].st));
      check($sformatf("vec%0d motor", i),  32'(motor),      32'(vecs[i].mo));
      check($sformatf("vec%0d valve", i),  32'(valve),      32'(vecs[i].va));
      check($sformatf("vec%0d capper", i), 32'(capper),     32'(vecs[i].ca));
      check($sformatf("vec%0d alarm", i),  32'(alarm),      32'(vecs[i].al));
      check($sformatf("vec%0d cnt", i),    32'(bottle_cnt), 32'(vecs[i].cnt));
    end
    exp_cnt = 4'd1;
    stop = 1'b0; start = 1'b0; pos_sensor = 1'b0; L = 1'b0;
    repeat (3) step();

    // Nominal bottle with exact phase widths (2-cycle sync + 1 transition cycle)
    pulse_start();
    wait_state(MOVE, "nom enter move");
    run_phase(MOVE, 6, SIG_POS, w);
    check("nom move width", 32'(w), 32'd9);
    check("nom fill state", 32'(state_o), 32'(FILL));
    pos_sensor = 1'b0;
    run_phase(FILL, 2, SIG_L, w);
    check("nom valve width", 32'(w), 32'd5);
    check("nom cap state", 32'(state_o), 32'(CAP));
    check("nom cnt in cap", 32'(bottle_cnt), 32'(exp_cnt));
    L = 1'b0;
    run_phase(CAP, -1, SIG_NONE, w);
    exp_cnt++;
    check("nom capper width", 32'(w), 32'd8);
    check("nom back to move", 32'(state_o), 32'(MOVE));
    check("nom motor again", 32'(motor), 32'd1);
    check("nom cnt inc", 32'(bottle_cnt), 32'(exp_cnt));

    // Move timeout: 5 ticks of 4 cycles
    run_phase(MOVE, -1, SIG_NONE, w);
    check("move to width", 32'(w), 32'd20);
    check("move to state", 32'(state_o), 32'(ERROR));
    check("move to alarm", 32'(alarm), 32'd1);
    check("move to motor", 32'(motor), 32'd0);
    stop = 1'b1;
    wait_state(IDLE, "move to clear");
    check("alarm cleared", 32'(alarm), 32'd0);
    stop = 1'b0;
    repeat (3) step();

    // Fill timeout: 3 ticks of 4 cycles
    pulse_start();
    wait_state(MOVE, "ft enter move");
    run_phase(MOVE, 1, SIG_POS, w);
    pos_sensor = 1'b0;
    run_phase(FILL, -1, SIG_NONE, w);
    check("fill to width", 32'(w), 32'd12);
    check("fill to state", 32'(state_o), 32'(ERROR));
    check("fill to outs", 32'({motor, valve, capper, alarm}), 32'b0001);
    start = 1'b1;
    repeat (5) step();
    check("error ignores start", 32'(state_o), 32'(ERROR));
    start = 1'b0;
    stop = 1'b1;
    wait_state(IDLE, "fill to clear");
    check("fill alarm cleared", 32'(alarm), 32'd0);
    stop = 1'b0;
    repeat (3) step();

    // Stop during CAP: bottle not counted
    pulse_start();
    wait_state(MOVE, "sc enter move");
    run_phase(MOVE, 1, SIG_POS, w);
    pos_sensor = 1'b0;
    run_phase(FILL, 0, SIG_L, w);
    check("sc cap state", 32'(state_o), 32'(CAP));
    L = 1'b0;
    step();
    stop = 1'b1;
    run_phase(CAP, -1, SIG_NONE, w);
    check("sc cap width", 32'(w), 32'd3);
    check("sc idle", 32'(state_o), 32'(IDLE));
    check("sc capper off", 32'(capper), 32'd0);
    check("sc cnt held", 32'(bottle_cnt), 32'(exp_cnt));
    stop = 1'b0;
    repeat (3) step();

    // Sixteen bottles wrap the 4-bit counter
    pulse_start();
    wait_state(MOVE, "wrap enter move");
    cnt0 = exp_cnt;
    for (int b = 0; b < 16; b++) begin
      run_phase(MOVE, 1, SIG_POS, w);
      pos_sensor = 1'b0;
      run_phase(FILL, 1, SIG_L, w);
      L = 1'b0;
      run_phase(CAP, -1, SIG_NONE, w);
      exp_cnt++;
      check($sformatf("wrap cnt %0d", b), 32'(bottle_cnt), 32'(exp_cnt));
    end
    check("wrap returns", 32'(bottle_cnt), 32'(cnt0));

    // L already high on FILL entry: valve for exactly one cycle
    L = 1'b1;
    run_phase(MOVE, 1, SIG_POS, w);
    pos_sensor = 1'b0;
    run_phase(FILL, -1, SIG_NONE, w);
    check("l early valve width", 32'(w), 32'd1);
    check("l early cap", 32'(state_o), 32'(CAP));
    L = 1'b0;
    run_phase(CAP, -1, SIG_NONE, w);
    exp_cnt++;
    check("l early cnt", 32'(bottle_cnt), 32'(exp_cnt));

    // Reset in FILL aborts immediately
    run_phase(MOVE, 1, SIG_POS, w);
    pos_sensor = 1'b0;
    check("rf in fill", 32'(state_o), 32'(FILL));
    step(); step();
    rst_n = 1'b0;
    step();
    check("rf state", 32'(state_o), 32'(IDLE));
    check("rf outs", 32'({motor, valve, capper, alarm}), 32'd0);
    check("rf cnt", 32'(bottle_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    pulse_start();
    wait_state(MOVE, "rf restart move");
    check("rf motor", 32'(motor), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
